// File: rtl/weight_sequencer_if.sv
// Weight stream and weight-store port bundle for weight_sequencer.
// slave  : the sequencer (stream sink, store controller).
// master : the environment (stream source and weight store).
interface weight_sequencer_if #(
    parameter int unsigned CLAUSEN = 140
);
    localparam int unsigned CW = $clog2(CLAUSEN) + 1;

    // Weight beat stream
    logic               s_valid;
    logic               s_ready;
    logic [255:0]       s_data;

    // Weight store write and read ports
    logic               wa_valid;
    logic [255:0]       wa_data;
    logic [31:0]        wa_offset;
    logic [CW-1:0]      wa_clauses;
    logic [CW-1:0]      wa_clause_no;
    logic signed [8:0]  wa_weight;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output wa_valid,
        output wa_data,
        output wa_offset,
        output wa_clauses,
        output wa_clause_no,
        input  wa_weight
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  wa_valid,
        input  wa_data,
        input  wa_offset,
        input  wa_clauses,
        input  wa_clause_no,
        output wa_weight
    );
endinterface

// File: rtl/weight_sequencer.sv
// Clause-weight store controller: loads a weight image as BEATS x 256-bit beats, then on start
// walks clause indices through the 3-cycle store read pipeline and sums the weights of the
// firing clauses into class_sum.
// Optional feature: define WSEQ_CLAMP_EN to clamp class_sum to [-THRESH, THRESH].
module weight_sequencer #(
    parameter int unsigned CLAUSEN = 140,
    parameter int unsigned BEATS   = 5,
    parameter int unsigned THRESH  = 128,
    localparam int unsigned CW     = $clog2(CLAUSEN) + 1,
    localparam int unsigned SUMW   = $clog2(CLAUSEN) + 9
) (
    input  logic                   clk,
    input  logic                   rst,
    weight_sequencer_if.slave      bus,
    input  logic                   start,
    input  logic [CW-1:0]          clauses,
    input  logic [CLAUSEN-1:0]     clause_fire,
    output logic                   loaded,
    output logic                   busy,
    output logic                   done,
    output logic signed [SUMW-1:0] class_sum
);

    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);
    localparam logic [CW-1:0] OneClause = CW'(1);
    localparam logic signed [SUMW-1:0] ThreshPos = SUMW'(THRESH);
    localparam logic signed [SUMW-1:0] ThreshNeg = -ThreshPos;

`ifdef WSEQ_CLAMP_EN
    localparam bit ClampEn = 1'b1;
`else
    localparam bit ClampEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoaded,
        StRun,
        StDrain
    } state_e;

    state_e                 state_q;
    logic [BW-1:0]          beat_q;
    logic                   wa_valid_q;
    logic [255:0]           wa_data_q;
    logic [31:0]            wa_offset_q;
    logic [CW-1:0]          wa_clauses_q;
    logic [CW-1:0]          wa_clause_no_q;
    logic [CLAUSEN-1:0]     fire_q;
    logic [2:0]             pv_q;      // issue pipeline: valid, [2] is the tail
    logic [2:0]             pf_q;      // issue pipeline: fire bit
    logic signed [SUMW-1:0] acc_q;
    logic signed [SUMW-1:0] acc_d;
    logic signed [SUMW-1:0] class_sum_q;
    logic signed [SUMW-1:0] class_sum_d;
    logic                   loaded_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   s_ready;
    logic                   beat_acc;
    logic                   start_acc;
    logic [CLAUSEN-1:0]     fire_sh;
    logic                   fire_bit;
    logic                   issue_last;
    logic                   drain_empty;

    // Handshake decode; start beats a coincident beat in LOADED, and reset blocks acceptance.
    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle, StLoad: s_ready = 1'b1;
                StLoaded:       s_ready = !start;
                default:        s_ready = 1'b0;
            endcase
        end
        beat_acc    = bus.s_valid && s_ready;
        start_acc   = (state_q == StLoaded) && start;
        // Shift instead of indexing so the wider clause index needs no truncation.
        fire_sh     = fire_q >> wa_clause_no_q;
        fire_bit    = fire_sh[0];
        issue_last  = (wa_clause_no_q == (wa_clauses_q - OneClause));
        // Tail entry is consumed on this edge, so only the first two stages decide emptiness.
        drain_empty = !pv_q[0] && !pv_q[1];
    end

    // Accumulator next value and the (optionally clamped) value published to class_sum.
    always_comb begin
        acc_d = acc_q;
        if (pv_q[2] && pf_q[2]) begin
            acc_d = acc_q + SUMW'(bus.wa_weight);
        end
        class_sum_d = acc_d;
        if (ClampEn) begin
            if (acc_d > ThreshPos) begin
                class_sum_d = ThreshPos;
            end else if (acc_d < ThreshNeg) begin
                class_sum_d = ThreshNeg;
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            wa_valid_q     <= 1'b0;
            wa_data_q      <= '0;
            wa_offset_q    <= '0;
            wa_clauses_q   <= '0;
            wa_clause_no_q <= '0;
            fire_q         <= '0;
            pv_q           <= '0;
            pf_q           <= '0;
            acc_q          <= '0;
            class_sum_q    <= '0;
            loaded_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            wa_valid_q <= 1'b0;
            done_q     <= 1'b0;
            pv_q       <= {pv_q[1:0], 1'b0};
            pf_q       <= {pf_q[1:0], 1'b0};
            acc_q      <= acc_d;

            if (beat_acc) begin
                wa_valid_q  <= 1'b1;
                wa_data_q   <= bus.s_data;
                wa_offset_q <= 32'(beat_q);
                if (beat_q == LastBeat) begin
                    beat_q   <= '0;
                    loaded_q <= 1'b1;
                    state_q  <= StLoaded;
                end else begin
                    beat_q   <= beat_q + 1'b1;
                    loaded_q <= 1'b0;
                    state_q  <= StLoad;
                end
            end

            unique case (state_q)
                StLoaded: begin
                    if (start_acc) begin
                        wa_clauses_q <= clauses;
                        fire_q       <= clause_fire;
                        acc_q        <= '0;
                        if (clauses == '0) begin
                            class_sum_q <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            wa_clause_no_q <= '0;
                            busy_q         <= 1'b1;
                            state_q        <= StRun;
                        end
                    end
                end
                StRun: begin
                    pv_q <= {pv_q[1:0], 1'b1};
                    pf_q <= {pf_q[1:0], fire_bit};
                    if (issue_last) begin
                        state_q <= StDrain;
                    end else begin
                        wa_clause_no_q <= wa_clause_no_q + OneClause;
                    end
                end
                StDrain: begin
                    if (drain_empty) begin
                        class_sum_q <= class_sum_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StLoaded;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.s_ready      = s_ready;
    assign bus.wa_valid     = wa_valid_q;
    assign bus.wa_data      = wa_data_q;
    assign bus.wa_offset    = wa_offset_q;
    assign bus.wa_clauses   = wa_clauses_q;
    assign bus.wa_clause_no = wa_clause_no_q;
    assign loaded           = loaded_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign class_sum        = class_sum_q;

endmodule

// File: tb/tb_weight_sequencer.sv
// Directed bench for weight_sequencer with a behavioural 3-cycle weight store.
module tb_weight_sequencer;

    localparam int unsigned CLAUSEN = 140;
    localparam int unsigned CW      = $clog2(CLAUSEN) + 1;
    localparam int unsigned SUMW    = $clog2(CLAUSEN) + 9;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [CW-1:0]          clauses;
    logic [CLAUSEN-1:0]     clause_fire;
    logic                   loaded;
    logic                   busy;
    logic                   done;
    logic signed [SUMW-1:0] class_sum;

    int n_chk  = 0;
    int n_pass = 0;

    weight_sequencer_if #(.CLAUSEN(CLAUSEN)) bus ();

    weight_sequencer #(
        .CLAUSEN (CLAUSEN),
        .BEATS   (5),
        .THRESH  (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .start       (start),
        .clauses     (clauses),
        .clause_fire (clause_fire),
        .loaded      (loaded),
        .busy        (busy),
        .done        (done),
        .class_sum   (class_sum)
    );

    always #5 clk = ~clk;

    // Weight store model: written one edge after wa_valid, read with 3-cycle latency.
    logic [1279:0] store_q;
    logic [CW-1:0] a0 = '0;
    logic [CW-1:0] a1 = '0;
    logic [CW-1:0] a2 = '0;

    always @(posedge clk) begin
        if (rst) begin
            store_q <= '0;
        end else if (bus.wa_valid) begin
            store_q[bus.wa_offset*256 +: 256] <= bus.wa_data;
        end
        a0 <= bus.wa_clause_no;
        a1 <= a0;
        a2 <= a1;
    end

    assign bus.wa_weight = store_q[a2*9 +: 9];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input logic [1279:0] img);
        for (int b = 0; b < 5; b++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = img[b*256 +: 256];
            step();
            check_eq("load_wa_valid", bus.wa_valid, 1);
            check_eq("load_wa_offset", bus.wa_offset, b);
            check_eq("load_wa_data", longint'(bus.wa_data[63:0]), longint'(img[b*256 +: 64]));
            check_eq("load_loaded", loaded, (b == 4) ? 1 : 0);
        end
        bus.s_valid = 1'b0;
        step();
        check_eq("load_wa_valid_drop", bus.wa_valid, 0);
    endtask

    // start in cycle c0; done expected at c0+N+4 (c0+1 when N=0).
    task automatic run_eval(input int n, input logic [CLAUSEN-1:0] fire, input longint exp,
                            input bit poke);
        int cnt;
        int extra;
        start       = 1'b1;
        clauses     = CW'(n);
        clause_fire = fire;
        if (poke) bus.s_valid = 1'b1;
        #1;
        if (poke) check_eq("start_wins_s_ready", bus.s_ready, 0);
        step();
        start       = 1'b0;
        bus.s_valid = 1'b0;
        if (poke) check_eq("start_wins_no_write", bus.wa_valid, 0);
        cnt = 1;
        while (!done && cnt < 400) begin
            if (poke && cnt == 2) begin
                start       = 1'b1;
                bus.s_valid = 1'b1;
                #1;
                check_eq("run_s_ready", bus.s_ready, 0);
                check_eq("run_busy", busy, 1);
            end
            step();
            start       = 1'b0;
            bus.s_valid = 1'b0;
            cnt++;
        end
        check_eq("done_latency", cnt, (n == 0) ? 1 : n + 4);
        check_eq("class_sum", class_sum, exp);
        check_eq("busy_at_done", busy, 0);
        step();
        check_eq("done_one_cycle", done, 0);
        check_eq("class_sum_hold", class_sum, exp);
        check_eq("loaded_kept", loaded, 1);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (done) extra++;
            end
            check_eq("no_extra_done", extra, 0);
        end
    endtask

    initial begin
        logic [1279:0]      img;
        logic [CLAUSEN-1:0] f;
        logic [CW-1:0]      cn;
        int                 cnt;
        int                 seen;

        rst         = 1'b1;
        start       = 1'b0;
        clauses     = '0;
        clause_fire = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        step();
        step();
        check_eq("rst_s_ready", bus.s_ready, 0);
        check_eq("rst_wa_valid", bus.wa_valid, 0);
        check_eq("rst_wa_offset", bus.wa_offset, 0);
        check_eq("rst_wa_clause_no", bus.wa_clause_no, 0);
        check_eq("rst_loaded", loaded, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_class_sum", class_sum, 0);
        rst = 1'b0;
        step();
        check_eq("idle_s_ready", bus.s_ready, 1);

        // start in IDLE is ignored
        start       = 1'b1;
        clauses     = CW'(5);
        clause_fire = '1;
        step();
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) seen++;
            step();
        end
        check_eq("idle_start_ignored", seen, 0);

        // every weight +3, all 140 clauses fire
        img = '0;
        for (int k = 0; k < 140; k++) img[k*9 +: 9] = 9'd3;
        load_image(img);
`ifdef WSEQ_CLAMP_EN
        run_eval(140, '1, 128, 1'b0);
`else
        run_eval(140, '1, 420, 1'b0);
`endif

        // clause k weight k-70
        img = '0;
        for (int k = 0; k < 140; k++) img[k*9 +: 9] = 9'(k - 70);
        load_image(img);
`ifdef WSEQ_CLAMP_EN
        run_eval(10, CLAUSEN'(10'b1010101010), -128, 1'b1);
        run_eval(10, CLAUSEN'(10'b1111111111), -128, 1'b0);
`else
        run_eval(10, CLAUSEN'(10'b1010101010), -325, 1'b1);
        run_eval(10, CLAUSEN'(10'b1111111111), -655, 1'b0);
`endif
        f      = '0;
        f[139] = 1'b1;
        run_eval(140, f, 69, 1'b0);

        // N=0: immediate done, no address activity
        cn = bus.wa_clause_no;
        run_eval(0, '1, 0, 1'b0);
        check_eq("n0_clause_no_hold", bus.wa_clause_no, cn);

        // reset in the middle of RUN at clause 37
        start       = 1'b1;
        clauses     = CW'(140);
        clause_fire = '1;
        step();
        start = 1'b0;
        cnt   = 1;
        while (bus.wa_clause_no != CW'(37) && cnt < 100) begin
            step();
            cnt++;
        end
        check_eq("reach_clause_37", cnt, 38);
        rst = 1'b1;
        step();
        check_eq("midrst_s_ready", bus.s_ready, 0);
        check_eq("midrst_wa_clause_no", bus.wa_clause_no, 0);
        check_eq("midrst_wa_clauses", bus.wa_clauses, 0);
        check_eq("midrst_wa_offset", bus.wa_offset, 0);
        check_eq("midrst_wa_data", longint'(bus.wa_data[63:0]), 0);
        check_eq("midrst_loaded", loaded, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_class_sum", class_sum, 0);
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 150; i++) begin
            if (done || busy) seen++;
            step();
        end
        check_eq("post_rst_start_ignored", seen, 0);
        check_eq("post_rst_class_sum", class_sum, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
